// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame width
// and the parity helper used by both directions of the link.
package uart_pkg;

  localparam int UART_DATA_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Narrower words are zero-extended by the caller; zeros do not change parity.
  function automatic logic parity_of(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits,
// advanced by an external one-clk baud tick, fed through a one-entry holding register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e state, state_n;
  logic [DATA_BITS-1:0] hold_data, shift_reg, shift_n;
  logic [CNT_W-1:0]     bit_cnt, bit_n;
  logic                 stop_cnt, stop_n;
  logic                 hold_valid, load, accept;
  logic                 parity_bit, parity_n, tx_n, done_n;

  assign in_ready = !hold_valid;
  assign tx_busy  = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n  = state;
    shift_n  = shift_reg;
    parity_n = parity_bit;
    bit_n    = bit_cnt;
    stop_n   = stop_cnt;
    tx_n     = tx;
    done_n   = 1'b0;
    load     = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          tx_n = 1'b1;
          load = hold_valid;
        end
        START: begin
          tx_n    = shift_reg[0];
          bit_n   = '0;
          state_n = DATA;
        end
        DATA: begin
          if (bit_cnt != LAST_BIT) begin
            shift_n = shift_reg >> 1;
            tx_n    = shift_reg[1];
            bit_n   = bit_cnt + 1'b1;
          end else if (PARITY_EN != 0) begin
            tx_n    = parity_bit;
            state_n = PARITY;
          end else begin
            tx_n    = 1'b1;
            stop_n  = 1'b0;
            state_n = STOP;
          end
        end
        PARITY: begin
          tx_n    = 1'b1;
          stop_n  = 1'b0;
          state_n = STOP;
        end
        STOP: begin
          if (stop_cnt != LAST_STOP) begin
            stop_n = 1'b1;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
            load    = hold_valid;
          end
        end
        default: begin
          tx_n    = 1'b1;
          state_n = IDLE;
        end
      endcase
      // Reload from the holding register: from IDLE, or straight out of the
      // last stop bit so consecutive frames have no idle bit between them.
      if (load) begin
        shift_n  = hold_data;
        parity_n = parity_of(9'(hold_data), 1'(PARITY_ODD));
        tx_n     = 1'b0;
        state_n  = START;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      hold_valid <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      tx_done  <= done_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      if (load)
        hold_valid <= 1'b0;
      else if (accept)
        hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      hold_data <= in_data;
    shift_reg  <= shift_n;
    parity_bit <= parity_n;
  end

endmodule
